fetch_pc_ctrl: RTL
==================

Name: fetch_pc_ctrl

Overview:
- Sequential wrapper around the combinational fetch stage of the five-stage Y86-64 pipeline.
- Holds the F pipeline register (predicted PC) and selects the real fetch PC (predicted, mispredict recovery, or ret target).
- Generates the load-use / ret / mispredict stall and bubble controls.
- Holds the F/D pipeline register that feeds decode.
- Upstream of fetch for the PC, downstream of fetch for the instruction fields.

Parameters:
RESET_PC, 64'h0, value loaded into the F predicted-PC register on reset.

Ports:
clk_i  in  1  clock; all state updates on the rising edge.
rst_n_i  in  1  synchronous, active-low reset.
f_predPC_i  in  64  predicted next PC from fetch.
f_icode_i, f_ifun_i, f_rA_i, f_rB_i  in  4 each  fetched instruction fields.
f_valC_i, f_valP_i  in  64 each  fetched constant and fall-through PC.
f_stat_i  in  3  fetch status (SAOK/SHLT/SADR/SINS).
d_srcA_i, d_srcB_i  in  4 each  decode source registers (F = none).
E_icode_i  in  4  E-stage icode.
E_dstM_i  in  4  E-stage memory destination register.
e_Cnd_i  in  1  E-stage branch condition.
M_icode_i, M_Cnd_i  in  4, 1  M-stage icode and latched condition.
M_valA_i  in  64  M-stage valA (fall-through PC of a jXX).
W_icode_i  in  4  W-stage icode.
W_valM_i  in  64  W-stage memory read value (ret target).
D_icode_i  in  4  current D-stage icode (from this block's D register, echoed back via decode).
f_pc_o  out  64  PC presented to fetch.
D_icode_o, D_ifun_o, D_rA_o, D_rB_o  out  4 each  F/D register fields.
D_valC_o, D_valP_o  out  64 each  F/D register fields.
D_stat_o  out  3  F/D register status.
F_stall_o, D_stall_o, D_bubble_o  out  1 each  hazard controls, exported for the E/M/W registers and the bench.
halted_o  out  1  sticky flag: a non-SAOK status has entered D.

Behaviour:
- **PC select (combinational):**
  - If M_icode==IJXX and !M_Cnd: f_pc_o = M_valA_i.
  - Else if W_icode==IRET: f_pc_o = W_valM_i.
  - Else f_pc_o = F_predPC register.
  - The mispredict case has priority.
- **Hazards (combinational):**
  - load_use = (E_icode in {IMRMOVQ, IPOPQ}) and E_dstM!=4'hF and (E_dstM==d_srcA or E_dstM==d_srcB).
  - ret_pend = IRET in {D_icode, E_icode, M_icode}.
  - mispred = E_icode==IJXX and !e_Cnd.
  - F_stall_o = load_use | ret_pend | halted.
  - D_stall_o = load_use | halted.
  - D_bubble_o = mispred | (ret_pend & !load_use).
  - The outputs are those pre-gate values.
  - Internally: when D_stall and D_bubble coincide, stall wins.
- **F register:**
  - Reset gives RESET_PC.
  - If !F_stall it loads f_predPC_i each cycle; otherwise it holds.
- **D register (registered, 1-cycle latency from f_* inputs):**
  - Reset and bubble both load the NOP pattern: icode=INOP, ifun=0, rA=rB=4'hF, valC=valP=0, stat=SAOK.
  - Stall holds the register.
  - Otherwise it loads the f_* inputs.
- **halted:**
  - Reset gives 0.
  - It is set on the edge where a non-SAOK f_stat_i is loaded into D (not stall, not bubble).
  - It stays set until reset, freezing F and D: the faulting instruction remains in D and nothing further is fetched.
- **Bubble masking:** a bubble on the same edge as a non-SAOK f_stat_i does not set halted. A wrong-path halt must not freeze the pipe.
- **Reset mid-operation:** rst_n_i low on any edge overrides stall, bubble and halted. f_pc_o = RESET_PC on the cycle after.
- **Widths:** all PC arithmetic is in fetch. This block only muxes 64-bit values, with no wrap handling.

Decomposition:
- **Shared define package:** icode constants (IHALT, INOP, IRRMOVQ, IIRMOVQ, IRMMOVQ, IMRMOVQ, IOPQ, IJXX, ICALL, IRET, IPUSHQ, IPOPQ), stat codes (SAOK, SHLT, SADR, SINS) and RNONE=4'hF. Add RNONE if it is absent.
- **Sub-module:** pipe_ctrl, the combinational hazard logic (load_use, ret_pend, mispred leading to stall/bubble). The E/M/W register blocks reuse it.
- The F and D registers stay in the top.

Test Plan:
1. Reset: rst_n_i=0 for 2 edges, then release -> f_pc_o=0, D_icode_o=INOP, D_rA_o=4'hF, D_stat_o=SAOK, halted_o=0.
2. Straight line: f_predPC_i=0x0A, then 0x13 -> f_pc_o follows with 1-cycle delay; D fields equal the previous cycle's f_* values.
3. Mispredict: E_icode=IJXX, e_Cnd=0 -> D_bubble_o=1 and D=NOP next edge. Next cycle M_icode=IJXX, M_Cnd=0, M_valA=0x26E -> f_pc_o=0x26E.
4. Load-use: E_icode=IMRMOVQ, E_dstM=4'hA, d_srcA=4'hA -> F_stall_o=D_stall_o=1; f_pc_o and D regs hold exactly one cycle.
5. Ret: D_icode=IRET -> D bubbles for 3 cycles while F stalls. Then W_icode=IRET, W_valM=0x235 -> f_pc_o=0x235 and fetch resumes.
6. Halt:
   - f_stat_i=SHLT loaded -> halted_o=1, D holds the halt instruction, f_pc_o is frozen until reset.
   - Repeat with D_bubble_o=1 on that edge -> halted_o stays 0.

Source files
------------

// File: rtl/fetch_pc_ctrl_pkg.sv
// Shared Y86-64 pipeline defines: icodes, status codes, F/D register layout.
package fetch_pc_ctrl_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RNONE   = 4'hF;

  localparam logic [2:0] SAOK    = 3'd1;
  localparam logic [2:0] SHLT    = 3'd2;
  localparam logic [2:0] SADR    = 3'd3;
  localparam logic [2:0] SINS    = 3'd4;

  // F/D pipeline register contents
  typedef struct packed {
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
    logic [63:0] valp;
    logic [2:0]  stat;
  } fd_reg_t;

  // Hazard controls produced by pipe_ctrl
  typedef struct packed {
    logic f_stall;
    logic d_stall;
    logic d_bubble;
  } hzd_t;

  localparam fd_reg_t FD_NOP = '{icode: INOP, ifun: 4'h0, ra: RNONE, rb: RNONE,
                                 valc: 64'h0, valp: 64'h0, stat: SAOK};

  // Instructions that write a register from memory in the M stage
  function automatic logic is_mem_load(input logic [3:0] icode);
    return (icode == IMRMOVQ) || (icode == IPOPQ);
  endfunction

endpackage

// File: rtl/fetch_pc_ctrl_pipe_ctrl.sv
// Combinational hazard detection: load-use, pending ret, branch mispredict.
module pipe_ctrl
  import fetch_pc_ctrl_pkg::*;
(
  input  logic [3:0] d_icode,
  input  logic [3:0] e_icode,
  input  logic [3:0] e_dstm,
  input  logic       e_cnd,
  input  logic [3:0] m_icode,
  input  logic [3:0] d_srca,
  input  logic [3:0] d_srcb,
  input  logic       halted,
  output hzd_t       hzd
);

  logic load_use, ret_pend, mispred;

  // Derive stall/bubble from the three hazard sources plus the halt freeze
  always_comb begin
    load_use = is_mem_load(e_icode) && (e_dstm != RNONE) &&
               ((e_dstm == d_srca) || (e_dstm == d_srcb));
    ret_pend = (d_icode == IRET) || (e_icode == IRET) || (m_icode == IRET);
    mispred  = (e_icode == IJXX) && !e_cnd;
    hzd          = '0;
    hzd.f_stall  = load_use | ret_pend | halted;
    hzd.d_stall  = load_use | halted;
    hzd.d_bubble = mispred | (ret_pend & ~load_use);
  end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch-side sequencing: F register, PC select, F/D register and halt latch.
module fetch_pc_ctrl
  import fetch_pc_ctrl_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [63:0] f_predPC_i,
  input  logic [3:0]  f_icode_i,
  input  logic [3:0]  f_ifun_i,
  input  logic [3:0]  f_rA_i,
  input  logic [3:0]  f_rB_i,
  input  logic [63:0] f_valC_i,
  input  logic [63:0] f_valP_i,
  input  logic [2:0]  f_stat_i,
  input  logic [3:0]  d_srcA_i,
  input  logic [3:0]  d_srcB_i,
  input  logic [3:0]  E_icode_i,
  input  logic [3:0]  E_dstM_i,
  input  logic        e_Cnd_i,
  input  logic [3:0]  M_icode_i,
  input  logic        M_Cnd_i,
  input  logic [63:0] M_valA_i,
  input  logic [3:0]  W_icode_i,
  input  logic [63:0] W_valM_i,
  input  logic [3:0]  D_icode_i,
  output logic [63:0] f_pc_o,
  output logic [3:0]  D_icode_o,
  output logic [3:0]  D_ifun_o,
  output logic [3:0]  D_rA_o,
  output logic [3:0]  D_rB_o,
  output logic [63:0] D_valC_o,
  output logic [63:0] D_valP_o,
  output logic [2:0]  D_stat_o,
  output logic        F_stall_o,
  output logic        D_stall_o,
  output logic        D_bubble_o,
  output logic        halted_o
);

  logic [63:0] pred_pc_q;
  fd_reg_t     d_q, f_in;
  hzd_t        hzd;
  logic        halted_q;
  logic        d_load;

  pipe_ctrl u_pipe_ctrl (
    .d_icode (D_icode_i),
    .e_icode (E_icode_i),
    .e_dstm  (E_dstM_i),
    .e_cnd   (e_Cnd_i),
    .m_icode (M_icode_i),
    .d_srca  (d_srcA_i),
    .d_srcb  (d_srcB_i),
    .halted  (halted_q),
    .hzd     (hzd)
  );

  // Fetch PC: mispredict recovery beats ret target beats prediction
  always_comb begin
    f_pc_o = pred_pc_q;
    if ((M_icode_i == IJXX) && !M_Cnd_i) f_pc_o = M_valA_i;
    else if (W_icode_i == IRET)          f_pc_o = W_valM_i;
  end

  // Pack fetched fields; a normal D load is neither stalled nor bubbled
  always_comb begin
    f_in   = '{icode: f_icode_i, ifun: f_ifun_i, ra: f_rA_i, rb: f_rB_i,
               valc: f_valC_i, valp: f_valP_i, stat: f_stat_i};
    d_load = !hzd.d_stall && !hzd.d_bubble;
  end

  // F register: predicted PC, held while fetch is stalled
  always_ff @(posedge clk_i) begin
    if (!rst_n_i)          pred_pc_q <= RESET_PC;
    else if (!hzd.f_stall) pred_pc_q <= f_predPC_i;
  end

  // F/D register: stall holds and has priority over bubble
  always_ff @(posedge clk_i) begin
    if (!rst_n_i)          d_q <= FD_NOP;
    else if (hzd.d_stall)  d_q <= d_q;
    else if (hzd.d_bubble) d_q <= FD_NOP;
    else                   d_q <= f_in;
  end

  // Halt latch: only a faulting instruction that really enters D freezes the pipe
  always_ff @(posedge clk_i) begin
    if (!rst_n_i)                         halted_q <= 1'b0;
    else if (d_load && (f_stat_i != SAOK)) halted_q <= 1'b1;
  end

  assign D_icode_o  = d_q.icode;
  assign D_ifun_o   = d_q.ifun;
  assign D_rA_o     = d_q.ra;
  assign D_rB_o     = d_q.rb;
  assign D_valC_o   = d_q.valc;
  assign D_valP_o   = d_q.valp;
  assign D_stat_o   = d_q.stat;
  assign F_stall_o  = hzd.f_stall;
  assign D_stall_o  = hzd.d_stall;
  assign D_bubble_o = hzd.d_bubble;
  assign halted_o   = halted_q;

endmodule
